// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety island: address-map rules,
// peripheral port indices and the peripheral demultiplexer state encoding.
package safety_island_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    typedef enum int unsigned {
        PeriphErrorSlv     = 0,
        PeriphSocCtrl      = 1,
        PeriphBootROM      = 2,
        PeriphGlobalPrepend = 3,
        PeriphDebug        = 4,
        PeriphEccManager   = 5,
        PeriphTimer        = 6,
        PeriphDmaCfg       = 7,
        PeriphCoreLocal    = 8
    } periph_outputs_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } periph_demux_state_e;

    localparam logic [31:0] PeriphErrRdata      = 32'hBADCAB1E;
    localparam int unsigned PeriphTimeoutCycles = 256;

endpackage

// File: rtl/safety_island_periph_addr_decode.sv
// Combinational address decode: offset from the island base, then rule match
// where the lowest-numbered matching rule wins.
module safety_island_periph_addr_decode import safety_island_pkg::*; #(
    parameter int unsigned                    NumRules = 8,
    parameter addr_map_rule_t [NumRules-1:0]  AddrMap  = '0,
    parameter logic [31:0]                    BaseAddr = 32'h0
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] idx
);

    logic [31:0] off;

    // Wrapping subtraction makes addresses below the base land far out of range.
    assign off = addr - BaseAddr;

    // Scan from the top so lower-indexed rules overwrite higher ones.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if ((off >= AddrMap[i].start_addr) && (off < AddrMap[i].end_addr)) begin
                hit = 1'b1;
                idx = AddrMap[i].idx;
            end
        end
    end

endmodule

// File: rtl/safety_island_periph_demux.sv
// Single-outstanding register-bus demux routing one request to a safety-island
// peripheral port. Define SAFETY_ISLAND_PERIPH_TIMEOUT_EN to enable the watchdog.
module safety_island_periph_demux import safety_island_pkg::*; #(
    parameter int unsigned                    NumPeriphs    = 9,
    parameter int unsigned                    NumRules      = 8,
    parameter addr_map_rule_t [NumRules-1:0]  AddrMap       = '0,
    parameter logic [31:0]                    BaseAddr      = 32'h0,
    parameter int unsigned                    TimeoutCycles = PeriphTimeoutCycles
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               slv_req_valid_i,
    output logic                               slv_req_ready_o,
    input  logic [31:0]                        slv_addr_i,
    input  logic                               slv_write_i,
    input  logic [31:0]                        slv_wdata_i,
    input  logic [3:0]                         slv_wstrb_i,
    output logic                               slv_rsp_valid_o,
    input  logic                               slv_rsp_ready_i,
    output logic [31:0]                        slv_rdata_o,
    output logic                               slv_error_o,
    output logic [NumPeriphs-1:0]              mst_valid_o,
    output logic [31:0]                        mst_addr_o,
    output logic [31:0]                        mst_wdata_o,
    output logic                               mst_write_o,
    output logic [3:0]                         mst_wstrb_o,
    input  logic [NumPeriphs-1:0]              mst_ready_i,
    input  logic [NumPeriphs-1:0][31:0]        mst_rdata_i,
    input  logic [NumPeriphs-1:0]              mst_error_i,
    output logic                               timeout_irq_o,
    output logic [$clog2(NumPeriphs)-1:0]      timeout_idx_o
);

    localparam int unsigned SelW = $clog2(NumPeriphs);

    periph_demux_state_e state_q, state_d;

    logic [31:0]     addr_q, wdata_q, rdata_q;
    logic [3:0]      wstrb_q;
    logic            write_q, error_q;
    logic [SelW-1:0] sel_q;

    logic            dec_hit, map_ok;
    logic [31:0]     dec_idx;
    logic            accept, done, timeout;

    safety_island_periph_addr_decode #(
        .NumRules (NumRules),
        .AddrMap  (AddrMap),
        .BaseAddr (BaseAddr)
    ) i_addr_decode (
        .addr (slv_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Rules pointing at the error slave or past the last port are answered internally.
    assign map_ok = dec_hit && (dec_idx != PeriphErrorSlv) && (dec_idx < NumPeriphs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (slv_req_valid_i) begin
                    accept  = 1'b1;
                    state_d = map_ok ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (mst_ready_i[sel_q]) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (slv_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completion takes priority over a watchdog abort in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= slv_addr_i;
                wdata_q <= slv_wdata_i;
                wstrb_q <= slv_wstrb_i;
                write_q <= slv_write_i;
                if (map_ok) begin
                    sel_q <= dec_idx[SelW-1:0];
                end else begin
                    rdata_q <= PeriphErrRdata;
                    error_q <= 1'b1;
                end
            end
            if (done) begin
                error_q <= mst_error_i[sel_q];
                rdata_q <= (write_q && !mst_error_i[sel_q]) ? '0 : mst_rdata_i[sel_q];
            end else if ((state_q == ACCESS) && timeout) begin
                rdata_q <= PeriphErrRdata;
                error_q <= 1'b1;
            end
        end
    end

`ifdef SAFETY_ISLAND_PERIPH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q;
    logic            irq_q;
    logic [SelW-1:0] tidx_q;

    assign timeout = (state_q == ACCESS) && (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            irq_q  <= 1'b0;
            tidx_q <= '0;
        end else begin
            irq_q <= 1'b0;
            if (accept) begin
                cnt_q <= '0;
            end else if ((state_q == ACCESS) && !mst_ready_i[sel_q]) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (timeout && !mst_ready_i[sel_q]) begin
                irq_q  <= 1'b1;
                tidx_q <= sel_q;
            end
        end
    end

    assign timeout_irq_o = irq_q;
    assign timeout_idx_o = tidx_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TimeoutCycles;
    assign timeout            = 1'b0;
    assign timeout_irq_o      = 1'b0;
    assign timeout_idx_o      = '0;
`endif

    always_comb begin
        mst_valid_o = '0;
        if (state_q == ACCESS) begin
            mst_valid_o[sel_q] = 1'b1;
        end
    end

    assign slv_req_ready_o = (state_q == IDLE);
    assign slv_rsp_valid_o = (state_q == RESP);
    assign slv_rdata_o     = rdata_q;
    assign slv_error_o     = error_q;
    assign mst_addr_o      = addr_q;
    assign mst_wdata_o     = wdata_q;
    assign mst_wstrb_o     = wstrb_q;
    assign mst_write_o     = write_q;

endmodule

// File: tb/tb_safety_island_periph_demux.sv
// Self-checking bench for safety_island_periph_demux: directed steps from the
// test plan followed by randomized transactions against a rule-table model.
module tb_safety_island_periph_demux;
    import safety_island_pkg::*;

    localparam int          NP   = 9;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h6000_0000;
`ifdef SAFETY_ISLAND_PERIPH_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam addr_map_rule_t R0 = '{idx: 32'(PeriphSocCtrl),    start_addr: 32'h0000_0000, end_addr: 32'h0000_1000};
    localparam addr_map_rule_t R1 = '{idx: 32'(PeriphBootROM),    start_addr: 32'h0000_1000, end_addr: 32'h0000_2000};
    localparam addr_map_rule_t R2 = '{idx: 32'(PeriphDebug),      start_addr: 32'h0000_2000, end_addr: 32'h0000_3000};
    localparam addr_map_rule_t R3 = '{idx: 32'(PeriphEccManager), start_addr: 32'h0000_3000, end_addr: 32'h0000_4000};
    localparam addr_map_rule_t R4 = '{idx: 32'(PeriphTimer),      start_addr: 32'h0000_8000, end_addr: 32'h0000_D000};
    localparam addr_map_rule_t R5 = '{idx: 32'(PeriphDmaCfg),     start_addr: 32'h0000_D000, end_addr: 32'h0000_F000};
    localparam addr_map_rule_t R6 = '{idx: 32'(PeriphCoreLocal),  start_addr: 32'h0000_E000, end_addr: 32'h0001_0000};
    localparam addr_map_rule_t R7 = '{idx: 32'(PeriphErrorSlv),   start_addr: 32'h0000_4000, end_addr: 32'h0000_4800};
    localparam addr_map_rule_t [7:0] BenchMap = {R7, R6, R5, R4, R3, R2, R1, R0};

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 slv_req_valid_i, slv_req_ready_o;
    logic [31:0]          slv_addr_i, slv_wdata_i, slv_rdata_o;
    logic                 slv_write_i, slv_error_o;
    logic [3:0]           slv_wstrb_i, mst_wstrb_o;
    logic                 slv_rsp_valid_o, slv_rsp_ready_i;
    logic [NP-1:0]        mst_valid_o, mst_ready_i, mst_error_i;
    logic [31:0]          mst_addr_o, mst_wdata_o;
    logic                 mst_write_o;
    logic [NP-1:0][31:0]  mst_rdata_i;
    logic                 timeout_irq_o;
    logic [3:0]           timeout_idx_o;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_tidx = '0;

    safety_island_periph_demux #(
        .NumPeriphs    (NP),
        .NumRules      (8),
        .AddrMap       (BenchMap),
        .BaseAddr      (BASE),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .slv_req_valid_i (slv_req_valid_i),
        .slv_req_ready_o (slv_req_ready_o),
        .slv_addr_i      (slv_addr_i),
        .slv_write_i     (slv_write_i),
        .slv_wdata_i     (slv_wdata_i),
        .slv_wstrb_i     (slv_wstrb_i),
        .slv_rsp_valid_o (slv_rsp_valid_o),
        .slv_rsp_ready_i (slv_rsp_ready_i),
        .slv_rdata_o     (slv_rdata_o),
        .slv_error_o     (slv_error_o),
        .mst_valid_o     (mst_valid_o),
        .mst_addr_o      (mst_addr_o),
        .mst_wdata_o     (mst_wdata_o),
        .mst_write_o     (mst_write_o),
        .mst_wstrb_o     (mst_wstrb_o),
        .mst_ready_i     (mst_ready_i),
        .mst_rdata_i     (mst_rdata_i),
        .mst_error_i     (mst_error_i),
        .timeout_irq_o   (timeout_irq_o),
        .timeout_idx_o   (timeout_idx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL sim_time_limit: observed=expired required=finished");
        $fatal(1);
    end

    // Reference decode: first rule in list order whose window holds the offset.
    function automatic int expected_port(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        for (int i = 0; i < 8; i++) begin
            if (off >= BenchMap[i].start_addr && off < BenchMap[i].end_addr)
                return (BenchMap[i].idx == 0 || BenchMap[i].idx >= NP) ? -1 : int'(BenchMap[i].idx);
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, slv_req_ready_o, 1);
        checkOutput({tag, "_rsp_valid"}, slv_rsp_valid_o, 0);
        checkOutput({tag, "_rdata"},     slv_rdata_o, 0);
        checkOutput({tag, "_error"},     slv_error_o, 0);
        checkOutput({tag, "_mst_valid"}, mst_valid_o, 0);
        checkOutput({tag, "_mst_addr"},  mst_addr_o, 0);
        checkOutput({tag, "_mst_wdata"}, mst_wdata_o, 0);
        checkOutput({tag, "_mst_wstrb"}, mst_wstrb_o, 0);
        checkOutput({tag, "_mst_write"}, mst_write_o, 0);
        checkOutput({tag, "_irq"},       timeout_irq_o, 0);
        checkOutput({tag, "_tidx"},      timeout_idx_o, 0);
    endtask

    // One full transaction; delay = ACCESS cycle in which the port answers, 0 = never.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                                 input logic [3:0] ws, input int delay, input logic [31:0] prd,
                                 input logic perr, input int stall);
        int          port, limit;
        logic        aborted;
        logic [8:0]  onehot;
        logic [31:0] exp_rdata;
        logic        exp_err;
        port    = expected_port(addr);
        onehot  = (port >= 0) ? (9'd1 << port) : 9'd0;
        aborted = 1'b0;
        checkOutput("idle_req_ready", slv_req_ready_o, 1);
        slv_req_valid_i = 1'b1;
        slv_addr_i      = addr;
        slv_write_i     = wr;
        slv_wdata_i     = wd;
        slv_wstrb_i     = ws;
        @(negedge clk_i);
        slv_req_valid_i = 1'b0;
        slv_addr_i      = $urandom;
        slv_write_i     = 1'($urandom);
        slv_wdata_i     = $urandom;
        slv_wstrb_i     = 4'($urandom);
        if (port < 0) begin
            exp_rdata = 32'hBADCAB1E;
            exp_err   = 1'b1;
        end else begin
            aborted = (delay == 0) && TimeoutEn;
            limit   = (delay != 0) ? delay : (TimeoutEn ? TO : 3 * TO);
            for (int cyc = 1; cyc <= limit; cyc++) begin
                checkOutput("access_mst_valid", mst_valid_o, onehot);
                checkOutput("access_rsp_valid", slv_rsp_valid_o, 0);
                checkOutput("access_mst_addr", mst_addr_o, addr);
                checkOutput("access_mst_wdata", mst_wdata_o, wd);
                checkOutput("access_mst_wstrb", mst_wstrb_o, ws);
                checkOutput("access_mst_write", mst_write_o, wr);
                mst_ready_i = 9'($urandom) & ~onehot;
                mst_error_i = 9'($urandom);
                for (int p = 0; p < NP; p++) mst_rdata_i[p] = $urandom;
                if (cyc == limit && !aborted) begin
                    mst_ready_i       = mst_ready_i | onehot;
                    mst_rdata_i[port] = prd;
                    mst_error_i[port] = perr;
                end
                @(negedge clk_i);
            end
            mst_ready_i = '0;
            if (aborted) begin
                exp_rdata = 32'hBADCAB1E;
                exp_err   = 1'b1;
                exp_tidx  = 4'(port);
            end else begin
                exp_err   = perr;
                exp_rdata = (wr && !perr) ? 32'h0 : prd;
            end
        end
        checkOutput("rsp_valid", slv_rsp_valid_o, 1);
        checkOutput("rsp_rdata", slv_rdata_o, exp_rdata);
        checkOutput("rsp_error", slv_error_o, exp_err);
        checkOutput("rsp_mst_valid", mst_valid_o, 0);
        checkOutput("rsp_req_ready", slv_req_ready_o, 0);
        checkOutput("rsp_irq", timeout_irq_o, aborted);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_i);
            checkOutput("stall_rsp_valid", slv_rsp_valid_o, 1);
            checkOutput("stall_rdata", slv_rdata_o, exp_rdata);
            checkOutput("stall_error", slv_error_o, exp_err);
            checkOutput("stall_req_ready", slv_req_ready_o, 0);
            checkOutput("stall_irq", timeout_irq_o, 0);
        end
        slv_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        slv_rsp_ready_i = 1'b0;
        checkOutput("done_rsp_valid", slv_rsp_valid_o, 0);
        checkOutput("done_irq", timeout_irq_o, 0);
        checkOutput("done_timeout_idx", timeout_idx_o, exp_tidx);
    endtask

    initial begin
        rst_ni          = 1'b0;
        slv_req_valid_i = 1'b0;
        slv_addr_i      = '0;
        slv_write_i     = 1'b0;
        slv_wdata_i     = '0;
        slv_wstrb_i     = '0;
        slv_rsp_ready_i = 1'b0;
        mst_ready_i     = '0;
        mst_rdata_i     = '0;
        mst_error_i     = '0;
        repeat (2) @(negedge clk_i);
        checkResetValues("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] directed: SocCtrl write, Timer read with error");
        applyStimulus(BASE + 32'h0, 1'b1, 32'hCAFE_F00D, 4'hA, 2, 32'hDEAD_0001, 1'b0, 0);
        applyStimulus(BASE + 32'h8004, 1'b0, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b1, 0);

        $display("[TB] directed: unmapped, wrapped, error-slave rule, overlap");
        applyStimulus(BASE + 32'h5000, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, 0);
        applyStimulus(BASE - 32'h4, 1'b1, 32'h5555_AAAA, 4'h3, 1, 32'h0, 1'b0, 0);
        applyStimulus(BASE + 32'h4010, 1'b0, 32'h0, 4'hF, 1, 32'h0, 1'b0, 0);
        applyStimulus(BASE + 32'hE100, 1'b0, 32'h0, 4'hF, 3, 32'h0BAD_F00D, 1'b0, 0);

        $display("[TB] directed: Debug watchdog, ready on last cycle, stalled response");
        applyStimulus(BASE + 32'h2010, 1'b0, 32'h0, 4'hF, 0, 32'h7777_0000, 1'b0, 2);
        applyStimulus(BASE + 32'h2010, 1'b0, 32'h0, 4'hF, TO, 32'h7777_1111, 1'b0, 0);
        applyStimulus(BASE + 32'h1004, 1'b0, 32'h0, 4'hF, 1, 32'hB007_0004, 1'b0, 5);

        $display("[TB] directed: reset during ACCESS");
        slv_req_valid_i = 1'b1;
        slv_addr_i      = BASE + 32'h2000;
        slv_write_i     = 1'b1;
        slv_wdata_i     = 32'h0123_4567;
        slv_wstrb_i     = 4'hF;
        @(negedge clk_i);
        slv_req_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("pre_reset_mst_valid", mst_valid_o, 9'b0_0001_0000);
        rst_ni = 1'b0;
        #1;
        checkResetValues("mid_reset");
        @(negedge clk_i);
        rst_ni   = 1'b1;
        exp_tidx = '0;
        @(negedge clk_i);
        checkOutput("post_reset_rsp_valid", slv_rsp_valid_o, 0);
        applyStimulus(BASE + 32'h3008, 1'b0, 32'h0, 4'hF, 2, 32'hECC0_0008, 1'b0, 1);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 20; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(0, 32'h10FFF));
            applyStimulus(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(1, 4)),
                          $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
